// File: rtl/mcu_ctrl_pkg.sv
// mcu_ctrl_pkg
// Shared definitions for the accumulator MCU sequencer: FSM state encoding,
// instruction field codes (mode / class / sub), status-register bit positions
// and the decoded-instruction record produced by mcu_ctrl_decode.
package mcu_ctrl_pkg;

    localparam int PSR_WIDTH = 2;
    localparam int PSR_Z_BIT = 0;
    localparam int PSR_C_BIT = 1;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        OPFETCH = 3'd2,
        OPLATCH = 3'd3,
        MEMRD   = 3'd4,
        EXEC    = 3'd5,
        HALT    = 3'd6
    } state_t;

    // Instruction bits [7:6]
    localparam logic [1:0] MODE_IMPLIED  = 2'b00;
    localparam logic [1:0] MODE_IMM      = 2'b01;
    localparam logic [1:0] MODE_DIRECT   = 2'b10;
    localparam logic [1:0] MODE_INDIRECT = 2'b11;

    // Instruction bits [5:4]
    localparam logic [1:0] CLASS_ALU   = 2'b00;
    localparam logic [1:0] CLASS_STORE = 2'b01;
    localparam logic [1:0] CLASS_JUMP  = 2'b10;
    localparam logic [1:0] CLASS_SYS   = 2'b11;

    // Instruction bits [3:0]
    localparam logic [3:0] SUB_JMP  = 4'h0;
    localparam logic [3:0] SUB_JZ   = 4'h1;
    localparam logic [3:0] SUB_JC   = 4'h2;
    localparam logic [3:0] SUB_HALT = 4'hF;

    typedef struct packed {
        logic needs_operand;   // a second instruction byte follows
        logic needs_mem_read;  // ALU operand comes from data memory
        logic is_store;        // legal store (direct or indirect)
        logic is_jump;         // legal jump (immediate mode, known sub)
        logic is_halt;
        logic illegal;
    } dec_t;

endpackage

// File: rtl/mcu_ctrl_decode.sv
// mcu_ctrl_decode
// Purely combinational instruction classifier.
// Ports:
//   inst : instruction word (mode [7:6], class [5:4], sub [3:0])
//   dec  : decoded attributes (see dec_t)
module mcu_ctrl_decode
    import mcu_ctrl_pkg::*;
#(
    parameter int INST_WIDTH = 8
) (
    input  logic [INST_WIDTH-1:0] inst,
    output dec_t                  dec
);

    logic [1:0] mode;
    logic [1:0] iclass;
    logic [3:0] sub;
    logic       mem_mode;
    logic       jump_sub_ok;

    assign mode   = inst[7:6];
    assign iclass = inst[5:4];
    assign sub    = inst[3:0];

    // Direct and indirect are the two modes that address data memory.
    assign mem_mode    = (mode == MODE_DIRECT) || (mode == MODE_INDIRECT);
    assign jump_sub_ok = (sub == SUB_JMP) || (sub == SUB_JZ) || (sub == SUB_JC);

    always_comb begin
        dec                = '0;
        dec.needs_operand  = (mode == MODE_IMM) || (mode == MODE_DIRECT);
        dec.needs_mem_read = (iclass == CLASS_ALU) && mem_mode;
        dec.is_store       = (iclass == CLASS_STORE) && mem_mode;
        dec.is_jump        = (iclass == CLASS_JUMP) && (mode == MODE_IMM) && jump_sub_ok;
        dec.is_halt        = (iclass == CLASS_SYS) && (sub == SUB_HALT);
        dec.illegal        = ((iclass == CLASS_STORE) && !mem_mode) ||
                             ((iclass == CLASS_JUMP) && !dec.is_jump);
    end

endmodule

// File: rtl/mcu_ctrl.sv
// mcu_ctrl
// Fetch/decode/execute sequencer for the accumulator MCU. Owns the program
// counter and produces all register-bank and data-memory strobes.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   stall             : hold request, only honoured in FETCH
//   imem_data         : instruction memory read data (one cycle after address)
//   opcode            : opcode latched in the register bank
//   psr               : status flags (Z, C)
//   jmp_target        : latched immediate, used as jump destination
//   imem_addr         : instruction memory address (= pc)
//   opcode_update, imm_update, acc_update, psr_update : register-bank strobes
//   opb_sel           : ALU operand B, 0=imm 1=dmem data
//   dmem_addr_sel     : dmem address, 0=imm 1=acc
//   dmem_re, dmem_we  : data memory strobes
//   halted            : high in HALT
//   illegal           : one-cycle pulse for illegal mode/class combinations
module mcu_ctrl
    import mcu_ctrl_pkg::*;
#(
    parameter int PC_WIDTH   = 8,
    parameter int INST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [INST_WIDTH-1:0] imem_data,
    input  logic [INST_WIDTH-1:0] opcode,
    input  logic [PSR_WIDTH-1:0]  psr,
    input  logic [INST_WIDTH-1:0] jmp_target,
    output logic [PC_WIDTH-1:0]   imem_addr,
    output logic                  opcode_update,
    output logic                  imm_update,
    output logic                  acc_update,
    output logic                  psr_update,
    output logic                  opb_sel,
    output logic                  dmem_addr_sel,
    output logic                  dmem_re,
    output logic                  dmem_we,
    output logic                  halted,
    output logic                  illegal
);

    state_t              state_reg, state_next;
    logic [PC_WIDTH-1:0] pc_reg, pc_next;
    dec_t                dec_imem;
    dec_t                dec_op;
    logic                op_indirect;
    logic                op_alu;
    logic                jump_taken;
    logic                unused_dec_bits;

    // The fresh instruction word steers DECODE; the latched opcode steers
    // every later state of the same instruction.
    mcu_ctrl_decode #(.INST_WIDTH(INST_WIDTH)) u_dec_imem (
        .inst (imem_data),
        .dec  (dec_imem)
    );

    mcu_ctrl_decode #(.INST_WIDTH(INST_WIDTH)) u_dec_op (
        .inst (opcode),
        .dec  (dec_op)
    );

    assign unused_dec_bits = &{1'b0, dec_imem.is_store, dec_imem.is_jump,
                               dec_imem.is_halt, dec_imem.illegal,
                               dec_op.needs_operand};

    assign op_indirect = (opcode[7:6] == MODE_INDIRECT);
    assign op_alu      = (opcode[5:4] == CLASS_ALU);

    always_comb begin
        jump_taken = 1'b0;
        if (dec_op.is_jump) begin
            case (opcode[3:0])
                SUB_JMP: jump_taken = 1'b1;
                SUB_JZ:  jump_taken = psr[PSR_Z_BIT];
                SUB_JC:  jump_taken = psr[PSR_C_BIT];
                default: jump_taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FETCH;
            pc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        opcode_update = 1'b0;
        imm_update    = 1'b0;
        acc_update    = 1'b0;
        psr_update    = 1'b0;
        opb_sel       = 1'b0;
        dmem_addr_sel = 1'b0;
        dmem_re       = 1'b0;
        dmem_we       = 1'b0;
        halted        = 1'b0;
        illegal       = 1'b0;

        case (state_reg)
            FETCH: begin
                if (!stall) begin
                    pc_next    = pc_reg + 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                opcode_update = 1'b1;
                // Direct ALU needs its operand byte before the memory read,
                // so needs_operand takes priority over needs_mem_read.
                if (dec_imem.needs_operand)
                    state_next = OPFETCH;
                else if (dec_imem.needs_mem_read)
                    state_next = MEMRD;
                else
                    state_next = EXEC;
            end
            OPFETCH: begin
                pc_next    = pc_reg + 1'b1;
                state_next = OPLATCH;
            end
            OPLATCH: begin
                imm_update = 1'b1;
                state_next = dec_op.needs_mem_read ? MEMRD : EXEC;
            end
            MEMRD: begin
                dmem_re       = 1'b1;
                dmem_addr_sel = op_indirect;
                state_next    = EXEC;
            end
            EXEC: begin
                state_next = dec_op.is_halt ? HALT : FETCH;
                illegal    = dec_op.illegal;
                if (op_alu) begin
                    acc_update = 1'b1;
                    psr_update = 1'b1;
                    opb_sel    = dec_op.needs_mem_read;
                end
                if (dec_op.is_store) begin
                    dmem_we       = 1'b1;
                    dmem_addr_sel = op_indirect;
                end
                if (jump_taken)
                    pc_next = jmp_target[PC_WIDTH-1:0];
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    assign imem_addr = pc_reg;

endmodule

// File: tb/tb_mcu_ctrl.sv
module tb_mcu_ctrl;
    import mcu_ctrl_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 stall = 1'b0;
    logic [7:0]           imem_data = 8'h00;
    logic [7:0]           opcode = 8'h00;
    logic [PSR_WIDTH-1:0] psr = '0;
    logic [7:0]           jmp_target = 8'h00;
    logic [7:0]           imem_addr;
    logic opcode_update, imm_update, acc_update, psr_update;
    logic opb_sel, dmem_addr_sel, dmem_re, dmem_we, halted, illegal;

    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;

    localparam logic [9:0] S_OPC  = 10'h200;
    localparam logic [9:0] S_IMM  = 10'h100;
    localparam logic [9:0] S_ACC  = 10'h080;
    localparam logic [9:0] S_PSR  = 10'h040;
    localparam logic [9:0] S_OPB  = 10'h020;
    localparam logic [9:0] S_DSEL = 10'h010;
    localparam logic [9:0] S_RE   = 10'h008;
    localparam logic [9:0] S_WE   = 10'h004;
    localparam logic [9:0] S_HALT = 10'h002;
    localparam logic [9:0] S_ILL  = 10'h001;

    logic [9:0] strb;
    assign strb = {opcode_update, imm_update, acc_update, psr_update, opb_sel,
                   dmem_addr_sel, dmem_re, dmem_we, halted, illegal};

    always #5 clk = ~clk;

    mcu_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .imem_data     (imem_data),
        .opcode        (opcode),
        .psr           (psr),
        .jmp_target    (jmp_target),
        .imem_addr     (imem_addr),
        .opcode_update (opcode_update),
        .imm_update    (imm_update),
        .acc_update    (acc_update),
        .psr_update    (psr_update),
        .opb_sel       (opb_sel),
        .dmem_addr_sel (dmem_addr_sel),
        .dmem_re       (dmem_re),
        .dmem_we       (dmem_we),
        .halted        (halted),
        .illegal       (illegal)
    );

    // Environment: synchronous instruction memory and register-bank latches.
    always @(posedge clk) begin
        imem_data <= mem[imem_addr];
        if (opcode_update) opcode <= imem_data;
        if (imm_update) jmp_target <= imem_data;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Fill memory with NOPs, hold reset, release; returns in cycle 0 (FETCH @0).
    task automatic start(input logic [7:0] b0, input logic [7:0] b1);
        rst = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h30;
        mem[0] = b0;
        mem[1] = b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        // ---- reset state ----
        for (int i = 0; i < 256; i++) mem[i] = 8'h30;
        step(2);
        check("rst_addr", 32'(imem_addr), 32'h0);
        check("rst_strb", 32'(strb), 32'h0);

        // ---- immediate ALU 0x41,0x05 ----
        start(8'h41, 8'h05);
        check("imm_c0_addr", 32'(imem_addr), 32'h0);
        step(1);
        check("imm_c1_strb", 32'(strb), 32'(S_OPC));
        check("imm_c1_addr", 32'(imem_addr), 32'h1);
        step(1);
        check("imm_c2_addr", 32'(imem_addr), 32'h1);
        step(1);
        check("imm_c3_strb", 32'(strb), 32'(S_IMM));
        check("imm_c3_addr", 32'(imem_addr), 32'h2);
        step(1);
        check("imm_c4_strb", 32'(strb), 32'(S_ACC | S_PSR));
        step(1);
        check("imm_c5_strb", 32'(strb), 32'h0);
        check("imm_c5_addr", 32'(imem_addr), 32'h2);
        check("imm_latch", 32'(jmp_target), 32'h05);

        // ---- direct ALU 0x81,0x10 ----
        start(8'h81, 8'h10);
        step(4);
        check("dir_c4_strb", 32'(strb), 32'(S_RE));
        step(1);
        check("dir_c5_strb", 32'(strb), 32'(S_ACC | S_PSR | S_OPB));
        step(1);
        check("dir_c6_addr", 32'(imem_addr), 32'h2);

        // ---- indirect ALU 0xC1 ----
        start(8'hC1, 8'h30);
        step(2);
        check("ind_c2_strb", 32'(strb), 32'(S_RE | S_DSEL));
        step(1);
        check("ind_c3_strb", 32'(strb), 32'(S_ACC | S_PSR | S_OPB));
        step(1);
        check("ind_c4_addr", 32'(imem_addr), 32'h1);

        // ---- indirect STORE 0xD0 ----
        start(8'hD0, 8'h30);
        step(2);
        check("st_c2_strb", 32'(strb), 32'(S_WE | S_DSEL));
        step(1);
        check("st_c3_addr", 32'(imem_addr), 32'h1);
        check("st_c3_strb", 32'(strb), 32'h0);

        // ---- illegal STORE immediate 0x50 ----
        start(8'h50, 8'h00);
        step(4);
        check("ill_c4_strb", 32'(strb), 32'(S_ILL));
        step(1);
        check("ill_c5_strb", 32'(strb), 32'h0);

        // ---- JZ taken / not taken ----
        psr = 2'b01;
        start(8'h61, 8'h20);
        step(5);
        check("jz_taken", 32'(imem_addr), 32'h20);
        psr = 2'b00;
        start(8'h61, 8'h20);
        step(5);
        check("jz_not_taken", 32'(imem_addr), 32'h02);

        // ---- JC taken on carry ----
        psr = 2'b10;
        start(8'h62, 8'h44);
        step(5);
        check("jc_taken", 32'(imem_addr), 32'h44);
        psr = 2'b00;

        // ---- jump to 0xFE, untaken JZ there, pc wraps ----
        start(8'h60, 8'hFE);
        mem[8'hFE] = 8'h61;
        mem[8'hFF] = 8'h20;
        step(5);
        check("jmp_fe", 32'(imem_addr), 32'hFE);
        step(5);
        check("wrap_addr", 32'(imem_addr), 32'h00);

        // ---- stall in FETCH ----
        stall = 1'b1;
        start(8'h30, 8'h30);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("stall_addr", 32'(imem_addr), 32'h0);
            check("stall_strb", 32'(strb), 32'h0);
        end
        stall = 1'b0;
        step(1);
        check("unstall_strb", 32'(strb), 32'(S_OPC));
        check("unstall_addr", 32'(imem_addr), 32'h1);

        // ---- HALT 0x3F ----
        start(8'h3F, 8'h30);
        step(3);
        for (int i = 0; i < 12; i++) begin
            check("halt_strb", 32'(strb), 32'(S_HALT));
            check("halt_addr", 32'(imem_addr), 32'h1);
            step(1);
        end

        // ---- reset during EXEC ----
        start(8'h41, 8'h05);
        step(4);
        check("pre_rst_acc", 32'(strb), 32'(S_ACC | S_PSR));
        rst = 1'b1;
        #1;
        check("async_rst_strb", 32'(strb), 32'h0);
        check("async_rst_addr", 32'(imem_addr), 32'h0);
        step(1);
        rst = 1'b0;
        check("post_rst_addr", 32'(imem_addr), 32'h0);
        step(1);
        check("post_rst_dec", 32'(strb), 32'(S_OPC));
        check("post_rst_a1", 32'(imem_addr), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
